mean_center_unit: RTL and testbench
===================================

# mean_center_unit

Parametrised, multi-channel successor to the fixed 4-channel centering subtractor in the FastICA front end. It works in two passes over a block of 2^LOG2N samples per channel:
- **Pass 1:** accumulates the block and derives the per-channel mean internally.
- **Pass 2:** streams the replayed block back out with the mean removed, saturated, under a valid/ready handshake.

It sits between the sample loader and the whitening stage.

## Interface
Parameters:
- CH, default 4: number of channels.
- W, default 26: signed sample width, two's complement.
- LOG2N, default 10: log2 of the block length N.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- GO, input, 1: one-cycle start pulse; honoured only in IDLE.
- En, input, 1: global clock enable. When 0, all state, counters and outputs hold.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block accepts in_data this cycle.
- in_data, input, CH*W: channel c is at bits [c*W +: W].
- out_valid, output, 1: out_data holds a centered sample.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, CH*W: centered samples, same packing as in_data.
- mean, output, CH*W: per-channel mean, valid from the end of MEAN until the next GO.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the N-th centered output is accepted.

## Operation
- **FSM states:** IDLE, ACCUM, MEAN, CENTER.
- **Transitions:**
  - IDLE → ACCUM on GO=1 (with En=1). This also clears the accumulators and the sample counter.
  - ACCUM → MEAN after the N-th accepted input.
  - MEAN → CENTER after 1 cycle.
  - CENTER → IDLE after the N-th accepted output.
- **Input transfer:** occurs on in_valid && in_ready && En.
- **in_ready:**
  - ACCUM: 1.
  - CENTER: !out_valid || out_ready.
  - IDLE and MEAN: 0.
- **Accumulators:** one per channel, signed, W+LOG2N bits wide, so they cannot overflow.
- **Mean:** computed in MEAN as acc >>> LOG2N, an arithmetic shift that floors toward −∞. The result is registered into mean at W bits, which is exact by construction.
- **CENTER arithmetic:**
  - Each channel computes x − mean at W+1 bits.
  - The result saturates to [−2^(W−1), 2^(W−1)−1].
  - It is registered into out_data and out_valid is set.
- **Output transfer:** occurs on out_valid && out_ready && En. If no new input transfers in the same cycle, out_valid clears.
- **Counter:** a single LOG2N+1-bit counter counts accepted inputs in ACCUM and accepted outputs in CENTER. It is cleared on each state entry.
- **Ignored conditions:** GO while busy; in_valid in IDLE or MEAN.
- **En=0 in any state:** full freeze, no transfers. out_valid and out_data hold stable.
- **Reset values (asynchronous rst_n=0):**
  - state = IDLE.
  - All accumulators, counters, mean and out_data = 0.
  - out_valid, done, busy = 0.
  - in_ready = 0.
- **Reset mid-block:** aborts immediately. No done pulse is generated and no partial output is emitted.

## Timing
- Output latency: 1 cycle from input transfer to out_valid in CENTER.
- Throughput: 1 sample per cycle in both passes when out_ready is held at 1.
- Block duration: N cycles of ACCUM + 1 cycle of MEAN + N cycles of CENTER (minimum), plus 1 cycle of GO.
- done asserts in the cycle after the N-th output transfer, coincident with busy falling.
- The mean output updates at the MEAN→CENTER edge.
- Backpressure: while out_valid=1 and out_ready=0, out_data holds and in_ready=0. An output transfer and an input transfer in the same cycle are both legal and keep out_valid=1.

## Structure
- **Shared package (with the other FastICA blocks):**
  - the state enum;
  - the localparams ACC_W = W+LOG2N and N = 1<<LOG2N;
  - a sat_w function that saturates W+1 bits down to W.
- **Sub-module:** per-channel datapath, named mean_center_lane, generated CH times. It contains the accumulator, the mean register, and the subtract-and-saturate logic. The parent holds the FSM, counter and handshake.

## Test plan
- **Basic centering** (CH=4, W=26, LOG2N=2): channel 0 fed 1,2,3,6 → mean 3; replayed outputs −2,−1,0,3; done pulses once. Other channels carry distinct ramps, which checks lane packing.
- **Negative floor:** channel 0 fed −1,−2,−2,−2 (sum −7) → mean = −2 (not −1); replaying −1 gives output 1.
- **Saturation** (W=8): accumulate four samples of −128 → mean −128; replaying 127 → output 127 (saturated); replaying −128 → output 0.
- **Backpressure:** hold out_ready=0 for 3 cycles mid-CENTER → out_data stable and in_ready=0; no sample is lost or duplicated; exactly N outputs are produced.
- **En / GO handling:** En=0 for 5 cycles in ACCUM → counter and accumulators frozen and the final mean is unchanged. GO pulsed during CENTER → ignored.
- **Reset mid-ACCUM:** rst_n asserted → all outputs read 0 immediately and state is IDLE. A subsequent GO and a full block produce the correct mean with no residue from the aborted block.

Source files
------------

// File: rtl/mean_center_unit_pkg.sv
// mean_center_unit_pkg: FSM state codes and saturation helper shared by the FastICA blocks
package mean_center_unit_pkg;
   localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, MEAN = 2'd2, CENTER = 2'd3;
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] d, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return d > hi ? hi : d < lo ? lo : d;
   endfunction
endpackage

// File: rtl/mean_center_unit_if.sv
// mean_center_unit_if: input and output sample streams with valid/ready handshakes
interface mean_center_unit_if #(parameter int CH = 4, parameter int W = 26);
   logic in_valid, in_ready, out_valid, out_ready;
   logic [CH*W-1:0] in_data, out_data;
   modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/mean_center_lane.sv
// mean_center_lane: one channel's accumulator, floored mean and saturating subtractor
module mean_center_lane
   import mean_center_unit_pkg::*;
#(
   parameter int W     = 26,
   parameter int LOG2N = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         acc_en,
   input  logic         mean_ld,
   input  logic         ctr_ld,
   input  logic [W-1:0] x,
   output logic [W-1:0] mean,
   output logic [W-1:0] y
);
   localparam int ACC_W = W + LOG2N;
   logic signed [ACC_W-1:0] acc;
   logic signed [W:0] diff;
   assign diff = $signed({x[W-1], x}) - $signed({mean[W-1], mean});
   // the floored mean of N W-bit samples always fits back into W bits
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc  <= '0;
         mean <= '0;
         y    <= '0;
      end else begin
         acc <= clr ? '0 : acc_en ? acc + ACC_W'($signed(x)) : acc;
         if (mean_ld) mean <= W'(acc >>> LOG2N);
         if (ctr_ld) y <= W'(sat_w(64'(diff), W));
      end
endmodule

// File: rtl/mean_center_unit.sv
// mean_center_unit: two-pass block mean removal; FSM, shared counter and handshake around CH lanes
module mean_center_unit
   import mean_center_unit_pkg::*;
#(
   parameter int CH    = 4,
   parameter int W     = 26,
   parameter int LOG2N = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                GO,
   input  logic                En,
   mean_center_unit_if.slave   b,
   output logic [CH*W-1:0]     mean,
   output logic                busy,
   output logic                done
);
   localparam int N = 1 << LOG2N;
   logic [1:0] state;
   logic [LOG2N:0] cnt;
   logic ov, xin, xout, last, clr, acc_en, mean_ld, ctr_ld;
   logic [CH*W-1:0] od;
   assign b.in_ready = state == ACCUM || (state == CENTER && (!ov || b.out_ready));
   assign xin        = b.in_valid && b.in_ready && En;
   assign xout       = ov && b.out_ready && En;
   assign last       = cnt == (LOG2N + 1)'(N - 1);
   assign clr        = state == IDLE && GO && En;
   assign acc_en     = state == ACCUM && xin;
   assign mean_ld    = state == MEAN && En;
   assign ctr_ld     = state == CENTER && xin;
   assign busy       = state != IDLE;
   assign b.out_valid = ov;
   assign b.out_data  = od;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ov    <= 1'b0;
         done  <= 1'b0;
      end else if (En) begin
         done <= 1'b0;
         case (state)
            IDLE: if (GO) begin
               state <= ACCUM;
               cnt   <= '0;
            end
            ACCUM: if (xin) begin
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) state <= MEAN;
            end
            MEAN: begin
               state <= CENTER;
               cnt   <= '0;
            end
            default: begin
               ov <= xin || (ov && !xout);
               if (xout) begin
                  cnt <= last ? '0 : cnt + 1'b1;
                  if (last) begin
                     state <= IDLE;
                     done  <= 1'b1;
                     ov    <= 1'b0;
                  end
               end
            end
         endcase
      end
   for (genvar c = 0; c < CH; c++) begin : g_lane
      mean_center_lane #(.W(W), .LOG2N(LOG2N)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (clr),
         .acc_en (acc_en),
         .mean_ld(mean_ld),
         .ctr_ld (ctr_ld),
         .x      (b.in_data[c*W +: W]),
         .mean   (mean[c*W +: W]),
         .y      (od[c*W +: W])
      );
   end
endmodule

// File: tb/tb_mean_center_unit.sv
// tb_mean_center_unit: directed blocks with a scoreboard queue checked by an output monitor
module tb_mean_center_unit;
   localparam int CH = 4, W = 26;
   localparam int MN = -(1 << 25), MX = (1 << 25) - 1;
   logic clk, rst_n, go, en, busy, done;
   logic [CH*W-1:0] mean, hold;
   logic [CH*W-1:0] q[$];
   int pass = 0, total = 0;

   mean_center_unit_if #(.CH(CH), .W(W)) b();
   mean_center_unit #(.CH(CH), .W(W), .LOG2N(2)) dut (
      .clk(clk), .rst_n(rst_n), .GO(go), .En(en), .b(b), .mean(mean), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int av [3][4][4] = '{
      '{'{1, 10, -5, 100}, '{2, 20, -6, 101}, '{3, 30, -7, 102}, '{6, 40, -8, 103}},
      '{'{-1, 7, -3, 1}, '{-2, 7, -3, 0}, '{-2, 7, -3, 0}, '{-2, 8, -3, 0}},
      '{'{MN, MX, 0, MX}, '{MN, MX, 0, MX}, '{MN, MX, 0, MN}, '{MN, MX, 0, MN}}};
   int rv [3][4][4] = '{
      '{'{1, 10, -5, 100}, '{2, 20, -6, 101}, '{3, 30, -7, 102}, '{6, 40, -8, 103}},
      '{'{-1, 0, -3, 1}, '{-2, 7, 0, 2}, '{0, 8, 3, 3}, '{5, -1, -6, 4}},
      '{'{MX, MN, MX, MX}, '{MN, MX, MN, MN}, '{0, 0, 5, 0}, '{-1, -1, -5, 1}}};
   int eo [3][4][4] = '{
      '{'{-2, -15, 2, -1}, '{-1, -5, 1, 0}, '{0, 5, 0, 1}, '{3, 15, -1, 2}},
      '{'{1, -7, 0, 1}, '{0, 0, 3, 2}, '{2, 1, 6, 3}, '{7, -8, -3, 4}},
      '{'{MX, MN, MX, MX}, '{0, 0, MN, MN + 1}, '{MX, MN + 1, 5, 1}, '{MX, MN, -5, 2}}};
   int em [3][4] = '{'{3, 25, -7, 101}, '{-2, 7, -3, 0}, '{MN, MX, 0, -1}};

   function automatic logic [CH*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
      logic [31:0] t[4];
      logic [CH*W-1:0] d;
      t = '{a0, a1, a2, a3};
      for (int c = 0; c < CH; c++) d[c*W +: W] = t[c][W-1:0];
      return d;
   endfunction

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a === e) pass++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   task automatic pulse_go();
      go = 1;
      @(posedge clk);
      #1 go = 0;
   endtask

   task automatic send(input logic [CH*W-1:0] d);
      int t = 0;
      b.in_valid = 1;
      b.in_data  = d;
      @(negedge clk);
      while (!(b.in_ready && en) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t == 50) begin
         total++;
         $display("FAIL send_timeout: in_ready never high");
      end
      @(posedge clk);
      #1 b.in_valid = 0;
   endtask

   task automatic run_block(input int k, input bit freeze, input bit gomid, input bit bp);
      int t = 0;
      pulse_go();
      for (int s = 0; s < 4; s++) begin
         if (freeze && s == 2) begin
            en = 0;
            b.in_valid = 1;
            b.in_data  = pk(av[k][s][0], av[k][s][1], av[k][s][2], av[k][s][3]);
            repeat (5) @(posedge clk);
            #1 en = 1;
            chk("busy_after_freeze", busy, 1);
         end
         send(pk(av[k][s][0], av[k][s][1], av[k][s][2], av[k][s][3]));
      end
      for (int s = 0; s < 4; s++) begin
         q.push_back(pk(eo[k][s][0], eo[k][s][1], eo[k][s][2], eo[k][s][3]));
         send(pk(rv[k][s][0], rv[k][s][1], rv[k][s][2], rv[k][s][3]));
         if (gomid && s == 1) pulse_go();
         if (bp && s == 1) begin
            b.out_ready = 0;
            @(negedge clk);
            hold = b.out_data;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("bp_data_hold", b.out_data, hold);
               chk("bp_in_ready", b.in_ready, 0);
               chk("bp_out_valid", b.out_valid, 1);
            end
            @(posedge clk);
            #1 b.out_ready = 1;
         end
      end
      @(negedge clk);
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("done_pulse", done, 1);
      chk("busy_low_at_done", busy, 0);
      chk("mean", mean, pk(em[k][0], em[k][1], em[k][2], em[k][3]));
      chk("outputs_pending", q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   always @(negedge clk)
      if (rst_n && en && b.out_valid && b.out_ready) begin
         if (q.size() == 0) begin
            total++;
            $display("FAIL extra_output: got %0h expected none", b.out_data);
         end else chk("out_data", b.out_data, q.pop_front());
      end

   initial begin
      clk = 0;
      rst_n = 0;
      go = 0;
      en = 1;
      b.in_valid = 0;
      b.in_data = '0;
      b.out_ready = 1;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", b.in_ready, 0);
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_mean", mean, 0);
      chk("rst_out_data", b.out_data, 0);
      @(posedge clk);
      #1 rst_n = 1;
      run_block(0, 0, 0, 0);
      run_block(1, 1, 1, 0);
      run_block(2, 0, 0, 1);
      pulse_go();
      send(pk(av[1][0][0], av[1][0][1], av[1][0][2], av[1][0][3]));
      send(pk(av[1][1][0], av[1][1][1], av[1][1][2], av[1][1][3]));
      rst_n = 0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", b.in_ready, 0);
      chk("midrst_out_valid", b.out_valid, 0);
      chk("midrst_mean", mean, 0);
      chk("midrst_out_data", b.out_data, 0);
      chk("midrst_done", done, 0);
      @(posedge clk);
      #1 rst_n = 1;
      run_block(0, 0, 0, 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
